// File: rtl/first_part_frame_ctrl_if.sv
// Bus bundle for first_part_frame_ctrl: pixel RAM read port plus the
// feed/return strobes of the first_part layer pipeline.
// master = frame controller, slave = RAM / pipeline side.
`timescale 1ns/1ps
interface first_part_frame_ctrl_if #(
  parameter int DATA_WIDHT = 32,
  parameter int IN_COUNT   = 2304
);
  localparam int ADDR_W = $clog2(IN_COUNT);

  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_WIDHT-1:0] mem_rd_data;
  logic [DATA_WIDHT-1:0] pipe_data_in;
  logic                  pipe_valid_in;
  logic                  pipe_valid_out;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rd_data,
    output pipe_data_in,
    output pipe_valid_in,
    input  pipe_valid_out
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rd_data,
    input  pipe_data_in,
    input  pipe_valid_in,
    output pipe_valid_out
  );
endinterface

// File: rtl/first_part_frame_ctrl.sv
// first_part_frame_ctrl: frame sequencer for the two-stage conv front end.
// On start it reads one 48x48 frame from a synchronous pixel RAM, streams it
// into the layer pipeline, counts the returned output beats and reports frame
// completion. Abort cancels the frame and flushes the pipeline for a fixed time.
// Optional build macro: FRAME_CTRL_TIMEOUT_EN adds a DRAIN watchdog that
// flags err and aborts when no output beat arrives for TIMEOUT_CYCLES cycles.
`timescale 1ns/1ps
module first_part_frame_ctrl #(
  parameter int DATA_WIDHT     = 32,
  parameter int IN_COUNT       = 2304,
  parameter int OUT_COUNT      = 1936,
  parameter int FLUSH_CYCLES   = 256,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  first_part_frame_ctrl_if.master bus,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_out_last,
  output logic                    o_err
);

  localparam int ADDR_W  = $clog2(IN_COUNT);
  localparam int OCNT_W  = $clog2(OUT_COUNT + 1);
  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(IN_COUNT - 1);
  localparam logic [OCNT_W-1:0]  OCNT_FULL  = OCNT_W'(OUT_COUNT);
  localparam logic [OCNT_W-1:0]  OCNT_LAST  = OCNT_W'(OUT_COUNT - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic                  r_mem_rd_en;
  logic                  r_rd_en_d;
  logic                  r_pipe_valid_in;
  logic [DATA_WIDHT-1:0] r_pipe_data;
  logic [OCNT_W-1:0]     r_out_cnt;
  logic [FLUSH_W-1:0]    r_flush_cnt;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  r_err;

  logic w_counting;
  logic w_beat;
  logic w_full;
  logic w_final;
  logic w_cnt_inc;
  logic w_err_set;
  logic w_timeout;
  logic w_start_ok;

  // A beat is only counted in FEED/DRAIN; an abort in the same cycle wins.
  assign w_counting = ((r_state == ST_FEED) || (r_state == ST_DRAIN)) && !i_abort;
  assign w_beat     = w_counting && bus.pipe_valid_out;
  assign w_full     = (r_out_cnt == OCNT_FULL);
  assign w_final    = w_beat && (r_out_cnt == OCNT_LAST);
  assign w_cnt_inc  = w_beat && !w_full;
  assign w_start_ok = (r_state == ST_IDLE) && i_start;

`ifdef FRAME_CTRL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;

  // DRAIN idle-cycle counter: cleared outside DRAIN and on every output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= {TO_W{1'b0}};
    end else if ((r_state != ST_DRAIN) || bus.pipe_valid_out) begin
      r_to_cnt <= {TO_W{1'b0}};
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_timeout = (r_state == ST_DRAIN) && !bus.pipe_valid_out && !i_abort &&
                     (r_to_cnt == TO_LAST);
`else
  // Watchdog compiled out: DRAIN never times out.
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_FEED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FEED: begin
        if (i_abort) begin
          w_state_nxt = ST_ABORT;
        end else if (r_mem_addr == ADDR_LAST) begin
          // Pipeline already delivered the whole frame: skip DRAIN.
          if (w_full || w_final) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end else begin
          w_state_nxt = ST_FEED;
        end
      end
      ST_DRAIN: begin
        if (i_abort || w_timeout) begin
          w_state_nxt = ST_ABORT;
        end else if (w_final) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      ST_ABORT: begin
        if (r_flush_cnt == FLUSH_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ABORT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Error sources: stray beat outside a frame, overflow, early final beat, timeout.
  always_comb begin
    w_err_set = 1'b0;
    if (bus.pipe_valid_out && ((r_state == ST_IDLE) || (r_state == ST_DONE))) begin
      w_err_set = 1'b1;
    end else if (w_beat && w_full) begin
      w_err_set = 1'b1;
    end else if (w_final && (r_state == ST_FEED)) begin
      w_err_set = 1'b1;
    end else if (w_timeout) begin
      w_err_set = 1'b1;
    end else begin
      w_err_set = 1'b0;
    end
  end

  // Control registers: read strobe, address, beat/flush counters, status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_rd_en  <= 1'b0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_out_cnt    <= {OCNT_W{1'b0}};
      r_flush_cnt  <= {FLUSH_W{1'b0}};
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_mem_rd_en  <= (w_state_nxt == ST_FEED);
      r_busy       <= (w_state_nxt == ST_FEED) || (w_state_nxt == ST_DRAIN) ||
                      (w_state_nxt == ST_ABORT);
      r_frame_done <= (w_state_nxt == ST_DONE);
      r_err        <= r_err || w_err_set;

      if (w_start_ok) begin
        r_mem_addr <= {ADDR_W{1'b0}};
      end else if ((r_state == ST_FEED) && (w_state_nxt == ST_FEED)) begin
        r_mem_addr <= r_mem_addr + ADDR_W'(1);
      end else begin
        r_mem_addr <= r_mem_addr;
      end

      if (w_start_ok) begin
        r_out_cnt <= {OCNT_W{1'b0}};
      end else if (w_cnt_inc) begin
        r_out_cnt <= r_out_cnt + OCNT_W'(1);
      end else begin
        r_out_cnt <= r_out_cnt;
      end

      if (r_state != ST_ABORT) begin
        r_flush_cnt <= {FLUSH_W{1'b0}};
      end else begin
        r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
      end
    end
  end

  // Pixel path: RAM data is registered once more, valid follows the read strobe by two cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_en_d       <= 1'b0;
      r_pipe_valid_in <= 1'b0;
      r_pipe_data     <= {DATA_WIDHT{1'b0}};
    end else begin
      r_rd_en_d       <= r_mem_rd_en;
      r_pipe_valid_in <= r_rd_en_d;
      r_pipe_data     <= bus.mem_rd_data;
    end
  end

  assign bus.mem_rd_en     = r_mem_rd_en;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.pipe_data_in  = r_pipe_data;
  assign bus.pipe_valid_in = r_pipe_valid_in;
  assign o_busy            = r_busy;
  assign o_frame_done      = r_frame_done;
  assign o_err             = r_err;
  // out_last must coincide with the final beat itself, so it is decoded from the count.
  assign o_out_last        = w_final;

endmodule

// File: tb/tb_first_part_frame_ctrl.sv
// Directed bench for first_part_frame_ctrl: RAM model, scripted pipeline beats,
// negedge monitor collecting timing facts, immediate-assertion checks.
`timescale 1ns/1ps
module tb_first_part_frame_ctrl;
  localparam int IN_COUNT  = 2304;
  localparam int OUT_COUNT = 1936;

  logic clk = 1'b0;
  logic rst;
  logic i_start;
  logic i_abort;
  logic o_busy;
  logic o_frame_done;
  logic o_out_last;
  logic o_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  first_part_frame_ctrl_if #(.DATA_WIDHT(32), .IN_COUNT(IN_COUNT)) vif ();

  first_part_frame_ctrl #(
    .DATA_WIDHT(32), .IN_COUNT(IN_COUNT), .OUT_COUNT(OUT_COUNT),
    .FLUSH_CYCLES(256), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .bus(vif),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_out_last(o_out_last), .o_err(o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ram_f(input int unsigned a);
    logic [31:0] aa;
    aa = a;
    return (aa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous pixel RAM: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (rst) vif.mem_rd_data <= 32'd0;
    else if (vif.mem_rd_en) vif.mem_rd_data <= ram_f(int'(vif.mem_addr));
  end

  // Monitor state
  logic rd_prev = 1'b0, vin_prev = 1'b0, err_prev = 1'b0;
  int rd_idx = 0, rd_rise = 0, rd_last = 0, rd_run = 0, addr_err = 0;
  int vin_idx = 0, vin_rise = 0, vin_last = 0, vin_run = 0, data_err = 0;
  int done_total = 0, done_cyc = 0, last_total = 0, last_cyc = 0;
  int busy_cnt = 0, err_rise = 0;

  always @(negedge clk) begin
    if (vif.mem_rd_en) begin
      if (!rd_prev) begin rd_idx = 0; rd_rise = cyc; end
      if (int'(vif.mem_addr) != rd_idx) addr_err++;
      rd_idx++; rd_run = rd_idx; rd_last = cyc;
    end
    rd_prev = vif.mem_rd_en;
    if (vif.pipe_valid_in) begin
      if (!vin_prev) begin vin_idx = 0; vin_rise = cyc; end
      if (vif.pipe_data_in !== ram_f(vin_idx)) data_err++;
      vin_idx++; vin_run = vin_idx; vin_last = cyc;
    end
    vin_prev = vif.pipe_valid_in;
    if (o_frame_done) begin done_total++; done_cyc = cyc; end
    if (o_out_last) begin last_total++; last_cyc = cyc; end
    if (o_busy) busy_cnt++;
    if (o_err && !err_prev) err_rise = cyc;
    err_prev = o_err;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // i = 0 is the start cycle; beats on cycles lat..lat+nbeats-1.
  task automatic drive_frame(input int lat, input int nbeats, input int ncyc,
                             input int abort_at, input int start2_at, output int t0);
    t0 = cyc;
    for (int i = 0; i < ncyc; i++) begin
      i_start = (i == 0) || (i == start2_at);
      i_abort = (i == abort_at);
      vif.pipe_valid_out = (i >= lat) && (i < lat + nbeats);
      step();
    end
    i_start = 1'b0;
    i_abort = 1'b0;
    vif.pipe_valid_out = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int t0, d0, l0, b0, de0, ae0;
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; vif.pipe_valid_out = 1'b0;
    step(); step();
    chk("rst_mem_rd_en", 32'(vif.mem_rd_en), 0);
    chk("rst_mem_addr", 32'(vif.mem_addr), 0);
    chk("rst_pipe_data_in", vif.pipe_data_in, 0);
    chk("rst_pipe_valid_in", 32'(vif.pipe_valid_in), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_frame_done", 32'(o_frame_done), 0);
    chk("rst_out_last", 32'(o_out_last), 0);
    chk("rst_err", 32'(o_err), 0);
    rst = 1'b0;
    step();

    // Normal frame, extra start while busy in FEED
    d0 = done_total; l0 = last_total; b0 = busy_cnt; de0 = data_err; ae0 = addr_err;
    drive_frame(500, OUT_COUNT, 2440, -1, 1000, t0);
    chk("f1_rd_rise", rd_rise, t0 + 1);
    chk("f1_rd_last", rd_last, t0 + 2304);
    chk("f1_rd_run", rd_run, 2304);
    chk("f1_addr_err", addr_err - ae0, 0);
    chk("f1_vin_rise", vin_rise, t0 + 3);
    chk("f1_vin_last", vin_last, t0 + 2306);
    chk("f1_vin_run", vin_run, 2304);
    chk("f1_data_err", data_err - de0, 0);
    chk("f1_last_cnt", last_total - l0, 1);
    chk("f1_last_cyc", last_cyc, t0 + 2435);
    chk("f1_done_cnt", done_total - d0, 1);
    chk("f1_done_cyc", done_cyc, t0 + 2436);
    chk("f1_busy_cycles", busy_cnt - b0, 2435);
    chk("f1_busy_end", 32'(o_busy), 0);
    chk("f1_err", 32'(o_err), 0);

    // Abort while issuing address 100, beats during ABORT ignored
    d0 = done_total; l0 = last_total; b0 = busy_cnt; de0 = data_err;
    drive_frame(50, 300, 360, 101, -1, t0);
    chk("f2_rd_last", rd_last, t0 + 101);
    chk("f2_rd_run", rd_run, 101);
    chk("f2_vin_last", vin_last, t0 + 103);
    chk("f2_vin_run", vin_run, 101);
    chk("f2_data_err", data_err - de0, 0);
    chk("f2_done_cnt", done_total - d0, 0);
    chk("f2_last_cnt", last_total - l0, 0);
    chk("f2_busy_cycles", busy_cnt - b0, 357);
    chk("f2_busy_end", 32'(o_busy), 0);
    chk("f2_err", 32'(o_err), 0);

    // Full frame after abort, start pulsed while in DONE
    d0 = done_total; b0 = busy_cnt; de0 = data_err;
    drive_frame(400, OUT_COUNT, 2340, -1, 2336, t0);
    chk("f3_rd_rise", rd_rise, t0 + 1);
    chk("f3_rd_run", rd_run, 2304);
    chk("f3_vin_run", vin_run, 2304);
    chk("f3_data_err", data_err - de0, 0);
    chk("f3_last_cyc", last_cyc, t0 + 2335);
    chk("f3_done_cnt", done_total - d0, 1);
    chk("f3_done_cyc", done_cyc, t0 + 2336);
    chk("f3_busy_cycles", busy_cnt - b0, 2335);
    chk("f3_busy_end", 32'(o_busy), 0);
    chk("f3_err", 32'(o_err), 0);

    // start and abort together in IDLE: start wins
    d0 = done_total;
    i_start = 1'b1; i_abort = 1'b1;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    chk("sa_busy", 32'(o_busy), 1);
    chk("sa_rd_en", 32'(vif.mem_rd_en), 1);
    chk("sa_addr", 32'(vif.mem_addr), 0);
    repeat (4) step();
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("sa_abort_rd_en", 32'(vif.mem_rd_en), 0);
    repeat (260) step();
    chk("sa_busy_end", 32'(o_busy), 0);
    chk("sa_done_cnt", done_total - d0, 0);

    // abort together with the final beat in DRAIN: abort wins
    d0 = done_total; l0 = last_total; b0 = busy_cnt;
    drive_frame(400, OUT_COUNT, 2600, 2335, -1, t0);
    chk("f6_last_cnt", last_total - l0, 0);
    chk("f6_done_cnt", done_total - d0, 0);
    chk("f6_busy_cycles", busy_cnt - b0, 2591);
    chk("f6_busy_end", 32'(o_busy), 0);
    chk("f6_err", 32'(o_err), 0);

    // One beat too many
    d0 = done_total; l0 = last_total;
    drive_frame(400, OUT_COUNT + 1, 2340, -1, -1, t0);
    chk("f4_done_cnt", done_total - d0, 1);
    chk("f4_last_cnt", last_total - l0, 1);
    chk("f4_err", 32'(o_err), 1);
    chk("f4_err_rise", err_rise, t0 + 2337);

    rst = 1'b1; step(); step();
    chk("rst2_err", 32'(o_err), 0);
    rst = 1'b0; step();

    // Beat while IDLE
    vif.pipe_valid_out = 1'b1;
    step();
    vif.pipe_valid_out = 1'b0;
    chk("idle_beat_err", 32'(o_err), 1);
    chk("idle_beat_busy", 32'(o_busy), 0);
    chk("idle_beat_rd_en", 32'(vif.mem_rd_en), 0);

    rst = 1'b1; step(); step();
    rst = 1'b0; step();

    // Whole frame returned while still feeding
    d0 = done_total;
    drive_frame(10, OUT_COUNT, 2310, -1, -1, t0);
    chk("f7_last_cyc", last_cyc, t0 + 1945);
    chk("f7_err_rise", err_rise, t0 + 1946);
    chk("f7_rd_run", rd_run, 2304);
    chk("f7_done_cnt", done_total - d0, 1);
    chk("f7_done_cyc", done_cyc, t0 + 2305);
    chk("f7_busy_end", 32'(o_busy), 0);

`ifdef FRAME_CTRL_TIMEOUT_EN
    rst = 1'b1; step(); step();
    rst = 1'b0; step();
    d0 = done_total; b0 = busy_cnt;
    drive_frame(100, 900, 2630, -1, -1, t0);
    chk("to_err_rise", err_rise, t0 + 2369);
    chk("to_err", 32'(o_err), 1);
    chk("to_done_cnt", done_total - d0, 0);
    chk("to_busy_cycles", busy_cnt - b0, 2624);
    chk("to_busy_end", 32'(o_busy), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
